// File: rtl/aes_round_key_store.sv
// -----------------------------------------------------------------------------
// aes_round_key_store
//
// Drives an AES-256 key schedule one round at a time and collects every 128-bit
// round key into a small key file, so the cipher datapath can read any round
// key at random without waiting on expansion.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      1-cycle pulse: latch key_i and begin expansion (idle/done/err only)
//   key_i        256-bit cipher key, sampled on an accepted start_i
//   ks_key_o     latched cipher key presented to the key schedule
//   ks_en_o      round request to the key schedule (held while waiting)
//   ks_round_o   round index being requested
//   ks_ready_i   key schedule has finished the requested round
//   ks_rkey_i    round key from the key schedule (valid the cycle after ready)
//   rd_idx_i     key file read index
//   rd_key_o     key file[rd_idx_i], combinational; 0 for indices past the end
//   keys_valid_o all round keys captured for the current cipher key
//   busy_o       expansion in progress
//   done_o       single-cycle pulse on capture of the last round key
//   err_o        sticky timeout flag, cleared by the next accepted start_i
// -----------------------------------------------------------------------------
module aes_round_key_store #(
  parameter int NUM_KEYS = 15,
  parameter int TIMEOUT  = 64
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic [255:0] ks_key_o,
  output logic         ks_en_o,
  output logic [3:0]   ks_round_o,
  input  logic         ks_ready_i,
  input  logic [127:0] ks_rkey_i,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o,
  output logic         keys_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST_ROUND = 4'(NUM_KEYS - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [255:0]  key_q,   key_d;
  logic          kf_we;
  logic [127:0]  kf_q [NUM_KEYS];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wait_d  = wait_q;
    key_d   = key_q;
    kf_we   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          key_d   = key_i;
          round_d = '0;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ks_ready_i) begin
          wait_d  = '0;
          state_d = CAPT;
        end else if (wait_q == WAIT_LAST) begin
          // TIMEOUT cycles spent in REQ without a ready
          wait_d  = '0;
          state_d = ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      CAPT: begin
        // Schedule output settles one cycle after ready, so capture here.
        kf_we = 1'b1;
        if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          round_d = round_q + 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      wait_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
    end
  end

  // Key file: cleared on reset, so it cannot map onto block RAM.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_kf
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        kf_q[gi] <= '0;
      end else if (kf_we && (round_q == 4'(gi))) begin
        kf_q[gi] <= ks_rkey_i;
      end
    end
  end

  // Read mux; indices past the last entry fall through to zero.
  always_comb begin
    rd_key_o = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rd_idx_i == 4'(i)) rd_key_o = kf_q[i];
    end
  end

  assign ks_key_o     = key_q;
  assign ks_en_o      = (state_q == REQ);
  assign ks_round_o   = round_q;
  assign keys_valid_o = (state_q == DONE);
  assign busy_o       = (state_q == REQ) || (state_q == CAPT);
  assign done_o       = (state_q == CAPT) && (round_q == LAST_ROUND);
  assign err_o        = (state_q == ERR);

endmodule

// File: tb/tb_aes_round_key_store.sv
`timescale 1ns/1ps
module tb_aes_round_key_store;

  logic         clk_i;
  logic         rst_n;
  logic         start_i;
  logic [255:0] key_i;
  logic [255:0] ks_key_o;
  logic         ks_en_o;
  logic [3:0]   ks_round_o;
  logic         ks_ready_i = 1'b0;
  logic [127:0] ks_rkey_i  = '0;
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_key_o;
  logic         keys_valid_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  // key schedule model configuration
  int delay_cfg = 3;   // ready asserted on the Nth cycle of ks_en_o
  int withhold  = 15;  // round for which ready is never given
  int en_cnt    = 0;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K1_R2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K1_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] JUNK   = {4{32'hdeadbeef}};

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_round_key_store #(.NUM_KEYS(15), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
    .ks_key_o(ks_key_o), .ks_en_o(ks_en_o), .ks_round_o(ks_round_o),
    .ks_ready_i(ks_ready_i), .ks_rkey_i(ks_rkey_i), .rd_idx_i(rd_idx_i),
    .rd_key_o(rd_key_o), .keys_valid_o(keys_valid_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Reference AES-256 key expansion: round key r of key
  function automatic logic [127:0] round_key(input logic [255:0] key, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Behavioural key schedule: ready on the delay_cfg-th en cycle,
  // round key valid only in the cycle after ready.
  always @(negedge clk_i) begin
    if (ks_ready_i) ks_rkey_i = round_key(ks_key_o, int'(ks_round_o));
    else            ks_rkey_i = JUNK;
    if (ks_en_o && (int'(ks_round_o) != withhold)) begin
      en_cnt++;
      ks_ready_i = (en_cnt >= delay_cfg);
    end else begin
      en_cnt = 0;
      ks_ready_i = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_key(input logic [255:0] k);
    key_i   = k;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Called at the first sample after start acceptance (cycle 1).
  task automatic wait_done(output int done_at, output int done_cnt, output int busy_cnt);
    done_at = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      if (done_o) begin done_cnt++; done_at = c; end
      if (busy_o) busy_cnt++;
      if (keys_valid_o) break;
      tick();
    end
    check("keys_valid_reached", 256'(keys_valid_o), 256'(1));
  endtask

  function automatic logic [255:0] idx_key(input logic [3:0] idx);
    return 256'(rd_key_o);
  endfunction

  task automatic read_check(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rd_idx_i = idx;
    #1;
    check(tag, 256'(rd_key_o), 256'(exp));
  endtask

  int d_at, d_cnt, b_cnt, n;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; key_i = '0; rd_idx_i = '0;
    tick(); tick();
    // reset state
    check("rst_ks_en", 256'(ks_en_o), 256'(0));
    check("rst_busy",  256'(busy_o), 256'(0));
    check("rst_done",  256'(done_o), 256'(0));
    check("rst_valid", 256'(keys_valid_o), 256'(0));
    check("rst_err",   256'(err_o), 256'(0));
    check("rst_round", 256'(ks_round_o), 256'(0));
    check("rst_key",   ks_key_o, 256'(0));
    check("rst_rdkey", 256'(rd_key_o), 256'(0));
    rst_n = 1'b1;
    tick();

    // full run, ready 3 cycles after en
    $display("TXN run K1 delay3");
    delay_cfg = 3;
    start_key(K1);
    check("run1_ks_key", ks_key_o, K1);
    wait_done(d_at, d_cnt, b_cnt);
    check("run1_done_cnt", 256'(d_cnt), 256'(1));
    check("run1_done_at",  256'(d_at), 256'(60));
    check("run1_busy_off", 256'(busy_o), 256'(0));
    read_check("run1_idx0",  4'd0,  K1[255:128]);
    read_check("run1_idx1",  4'd1,  K1[127:0]);
    read_check("run1_idx2",  4'd2,  K1_R2);
    read_check("run1_idx14", 4'd14, K1_R14);

    // immediate ready: 2 cycles per round
    $display("TXN run K1 immediate ready");
    delay_cfg = 1;
    start_key(K1);
    wait_done(d_at, d_cnt, b_cnt);
    check("imm_done_at",  256'(d_at), 256'(30));
    check("imm_busy_cnt", 256'(b_cnt), 256'(30));
    check("imm_done_cnt", 256'(d_cnt), 256'(1));

    // ready withheld at round 5 -> timeout
    $display("TXN timeout at round 5");
    withhold = 5;
    start_key(K1);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      if (err_o) break;
      if (ks_en_o && ks_round_o == 4'd5) n++;
      tick();
    end
    check("to_err",      256'(err_o), 256'(1));
    check("to_wait_cyc", 256'(n), 256'(64));
    check("to_en",       256'(ks_en_o), 256'(0));
    check("to_valid",    256'(keys_valid_o), 256'(0));
    check("to_busy",     256'(busy_o), 256'(0));
    tick(); tick();
    check("to_err_sticky", 256'(err_o), 256'(1));

    // restart from ERR with K2
    $display("TXN restart K2 from err");
    withhold = 15;
    start_key(K2);
    check("rs_err_clr", 256'(err_o), 256'(0));
    check("rs_ks_key",  ks_key_o, K2);
    wait_done(d_at, d_cnt, b_cnt);
    check("rs_done_at", 256'(d_at), 256'(30));
    read_check("rs_idx0",  4'd0,  K2[255:128]);
    read_check("rs_idx1",  4'd1,  K2[127:0]);
    read_check("rs_idx7",  4'd7,  round_key(K2, 7));
    read_check("rs_idx14", 4'd14, round_key(K2, 14));

    // start_i mid-expansion is ignored
    $display("TXN mid-expansion start ignored");
    delay_cfg = 3;
    start_key(K1);
    for (int c = 0; c < 10; c++) tick();
    key_i = K2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("mid_ks_key", ks_key_o, K1);
    check("mid_busy",   256'(busy_o), 256'(1));
    wait_done(d_at, d_cnt, b_cnt);
    check("mid_done_cnt", 256'(d_cnt), 256'(1));
    read_check("mid_idx1",  4'd1,  K1[127:0]);
    read_check("mid_idx14", 4'd14, K1_R14);

    // async reset during round 7
    $display("TXN reset during round 7");
    start_key(K1);
    for (int c = 0; c < 200; c++) begin
      if (ks_round_o == 4'd7) break;
      tick();
    end
    check("rr_round7", 256'(ks_round_o), 256'(7));
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_ks_en",  256'(ks_en_o), 256'(0));
    check("rr_busy",   256'(busy_o), 256'(0));
    check("rr_round",  256'(ks_round_o), 256'(0));
    check("rr_ks_key", ks_key_o, 256'(0));
    check("rr_flags",  256'({keys_valid_o, done_o, err_o}), 256'(0));
    for (int i = 0; i < 16; i++) read_check($sformatf("rr_rd%0d", i), 4'(i), 128'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // full run, then out-of-range read
    $display("TXN run K1 then idx15 read");
    delay_cfg = 1;
    start_key(K1);
    wait_done(d_at, d_cnt, b_cnt);
    read_check("oor_idx15", 4'd15, 128'h0);
    read_check("oor_idx14", 4'd14, K1_R14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
